// File: rtl/saturn_bus_ctrl_if.sv
// saturn_bus_ctrl_if: nibble bus and debug serial signals shared by controller, ROM and UART
interface saturn_bus_ctrl_if;
    logic       o_bus_clk_en;
    logic       o_bus_is_data;
    logic [3:0] o_bus_nibble_out;
    logic [3:0] i_bus_nibble_in;
    logic [7:0] o_char_to_send;
    logic [9:0] o_char_counter;
    logic       o_char_valid;
    logic       o_char_send;
    logic       i_serial_busy;
    modport master (
        output o_bus_clk_en, o_bus_is_data, o_bus_nibble_out,
        output o_char_to_send, o_char_counter, o_char_valid, o_char_send,
        input  i_bus_nibble_in, i_serial_busy
    );
    modport slave (
        input  o_bus_clk_en, o_bus_is_data, o_bus_nibble_out,
        input  o_char_to_send, o_char_counter, o_char_valid, o_char_send,
        output i_bus_nibble_in, i_serial_busy
    );
endinterface

// File: rtl/saturn_bus_ctrl.sv
// saturn_bus_ctrl: Saturn bus master fetching ROM nibbles and printing each as hex on the debug UART
module saturn_bus_ctrl #(
    parameter int MAX_NIBBLES = 64,
    parameter int LINE_LEN    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic [3:0]        i_phases,
    input  logic [1:0]        i_phase,
    input  logic [31:0]       i_cycle_ctr,
    output logic              o_debug_cycle,
    output logic              o_instr_decoded,
    output logic              o_halt,
    saturn_bus_ctrl_if.master bus
);
    typedef enum logic [3:0] {LOAD_CMD, ADDR0, ADDR1, ADDR2, ADDR3, ADDR4, READ_CMD, FETCH, PRINT} state_t;
    localparam int CW = $clog2(MAX_NIBBLES + 1);
    state_t        state_q;
    logic [19:0]   pc_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bus_nib_q;
    logic          bus_data_q;
    logic [1:0]    step_q, cidx_q;
    logic [7:0]    char_q;
    logic [9:0]    ccnt_q;
    logic          valid_q, send_q, debug_q, dec_q, halt_q;
    logic [3:0]    nib_d;
    logic [2:0]    ai_d;
    logic [7:0]    hex_d;
    logic          data_d, run_d, eol_d, last_d;
    logic          unused_inputs;
    assign unused_inputs = ^{i_phases, i_cycle_ctr};
    always_comb begin
        run_d  = i_clk_en && !debug_q && !halt_q;
        data_d = state_q == FETCH;
        ai_d   = 3'(state_q - ADDR0);
        nib_d  = state_q == LOAD_CMD ? 4'h4 : state_q == READ_CMD ? 4'h2 : data_d ? 4'h0 : 4'(pc_q >> {ai_d, 2'b00});
        hex_d  = bus.i_bus_nibble_in < 4'd10 ? 8'h30 + {4'h0, bus.i_bus_nibble_in} : 8'h37 + {4'h0, bus.i_bus_nibble_in};
        eol_d  = int'(cnt_q) % LINE_LEN == 0;
        last_d = int'(cnt_q) == MAX_NIBBLES;
    end
    // step_q: 1 = char offered, 2 = send strobe high, 3 = valid-low gap
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= LOAD_CMD;
            pc_q       <= '0;
            cnt_q      <= '0;
            bus_nib_q  <= '0;
            bus_data_q <= 1'b0;
            step_q     <= '0;
            cidx_q     <= '0;
            char_q     <= '0;
            ccnt_q     <= '0;
            valid_q    <= 1'b0;
            send_q     <= 1'b0;
            debug_q    <= 1'b0;
            dec_q      <= 1'b0;
            halt_q     <= 1'b0;
        end else if (i_clk_en) begin
            dec_q  <= 1'b0;
            send_q <= 1'b0;
            if (run_d && i_phase == 2'd0) begin
                bus_nib_q  <= nib_d;
                bus_data_q <= data_d;
            end
            if (run_d && i_phase == 2'd3) begin
                if (state_q == FETCH) begin
                    dec_q   <= 1'b1;
                    debug_q <= 1'b1;
                    cnt_q   <= cnt_q + 1'b1;
                    pc_q    <= pc_q + 1'b1;
                    char_q  <= hex_d;
                    valid_q <= 1'b1;
                    cidx_q  <= 2'd0;
                    step_q  <= 2'd1;
                    state_q <= PRINT;
                end else begin
                    state_q <= state_t'(state_q + 1'b1);
                end
            end
            if (state_q == PRINT) begin
                if (step_q == 2'd1 && !bus.i_serial_busy) begin
                    send_q <= 1'b1;
                    ccnt_q <= ccnt_q + 1'b1;
                    step_q <= 2'd2;
                end
                if (step_q == 2'd2) begin
                    valid_q <= 1'b0;
                    step_q  <= 2'd3;
                end
                if (step_q == 2'd3) begin
                    if ((cidx_q == 2'd0 && eol_d) || cidx_q == 2'd1) begin
                        char_q  <= cidx_q == 2'd0 ? 8'h0D : 8'h0A;
                        cidx_q  <= cidx_q + 1'b1;
                        valid_q <= 1'b1;
                        step_q  <= 2'd1;
                    end else begin
                        debug_q <= 1'b0;
                        halt_q  <= last_d;
                        step_q  <= 2'd0;
                        state_q <= FETCH;
                    end
                end
            end
        end
    end
    assign bus.o_bus_clk_en     = i_reset && i_phase == 2'd1 && run_d;
    assign bus.o_bus_is_data    = bus_data_q;
    assign bus.o_bus_nibble_out = bus_nib_q;
    assign bus.o_char_to_send   = char_q;
    assign bus.o_char_counter   = ccnt_q;
    assign bus.o_char_valid     = valid_q;
    assign bus.o_char_send      = send_q;
    assign o_debug_cycle        = debug_q;
    assign o_instr_decoded      = dec_q;
    assign o_halt               = halt_q;
endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// tb_saturn_bus_ctrl: directed bench with phase generator, auto-incrementing ROM and UART monitor
module tb_saturn_bus_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, busy = 1'b0;
    logic [1:0]  phase;
    logic [3:0]  phases;
    logic [31:0] cyc;
    logic        debug, decoded, halt;
    int          vectors = 0, errors = 0;
    string       hx = "0123456789ABCDEF";
    saturn_bus_ctrl_if bus();
    saturn_bus_ctrl dut (
        .i_clk(clk), .i_reset(rst_n), .i_clk_en(clk_en), .i_phases(phases), .i_phase(phase),
        .i_cycle_ctr(cyc), .o_debug_cycle(debug), .o_instr_decoded(decoded), .o_halt(halt), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase <= 2'd0;
            cyc   <= '0;
        end else if (clk_en && !debug) begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) cyc <= cyc + 1;
        end
    assign phases = 4'b0001 << phase;
    function automatic logic [3:0] rom(input logic [19:0] a);
        return 4'(a * 7 + 10);
    endfunction
    logic [19:0] raddr = '0;
    logic [3:0]  rdout = '0;
    int          acnt = 0;
    always @(posedge clk)
        if (bus.o_bus_clk_en) begin
            if (bus.o_bus_is_data) begin
                rdout <= rom(raddr);
                raddr <= raddr + 1;
            end else if (acnt > 0) begin
                raddr[4*(5-acnt) +: 4] <= bus.o_bus_nibble_out;
                acnt <= acnt - 1;
            end else if (bus.o_bus_nibble_out == 4'h4) acnt <= 5;
        end
    assign bus.i_bus_nibble_in = rdout;
    assign bus.i_serial_busy   = busy;
    logic       en_edge = 1'b0;
    logic [7:0] sent[$];
    logic [6:0] xfer[$];
    int         ndec = 0;
    always @(posedge clk) en_edge <= clk_en;
    always @(negedge clk)
        if (rst_n) begin
            if (bus.o_bus_clk_en) xfer.push_back({phase, bus.o_bus_is_data, bus.o_bus_nibble_out});
            if (en_edge && bus.o_char_send) sent.push_back(bus.o_char_to_send);
            if (en_edge && decoded) ndec++;
        end
    task automatic nclk(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask
    task automatic drive_edge;
        @(posedge clk);
        #2;
    endtask
    task automatic test_reset;
        clk_en = 1'b1;
        rst_n = 1'b0;
        nclk(3);
        vectors++;
        if ({debug, decoded, halt, bus.o_bus_clk_en, bus.o_bus_is_data, bus.o_bus_nibble_out, bus.o_char_to_send,
             bus.o_char_counter, bus.o_char_valid, bus.o_char_send} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got dbg=%b dec=%b halt=%b ben=%b nib=%h chr=%h cnt=%0d val=%b snd=%b, want all 0",
                     debug, decoded, halt, bus.o_bus_clk_en, bus.o_bus_nibble_out, bus.o_char_to_send,
                     bus.o_char_counter, bus.o_char_valid, bus.o_char_send);
        end
        drive_edge();
        rst_n = 1'b1;
    endtask
    task automatic test_addr_cycles(input int base);
        logic [3:0] exp_nib[8] = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
        for (int i = 0; i < 200 && xfer.size() < base + 8; i++) nclk(1);
        vectors++;
        if (xfer.size() < base + 8) begin
            errors++;
            $display("FAIL addr_timeout: got %0d transfers, want %0d", xfer.size() - base, 8);
        end else
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (xfer[base+k] !== {2'd1, k == 7, exp_nib[k]}) begin
                    errors++;
                    $display("FAIL addr_xfer%0d: got ph=%0d data=%b nib=%h, want ph=1 data=%b nib=%h",
                             k, xfer[base+k][6:5], xfer[base+k][4], xfer[base+k][3:0], k == 7, exp_nib[k]);
                end
            end
    endtask
    task automatic test_first_fetch;
        for (int i = 0; i < 100 && ndec < 1; i++) nclk(1);
        vectors++;
        if ({decoded, debug, bus.o_char_valid, bus.o_char_to_send} !== {3'b111, 8'h41}) begin
            errors++;
            $display("FAIL fetch0_char: got dec=%b dbg=%b val=%b chr=%h, want 1 1 1 41",
                     decoded, debug, bus.o_char_valid, bus.o_char_to_send);
        end
        for (int i = 0; i < 20 && debug; i++) nclk(1);
        vectors++;
        if ({sent.size() == 1, bus.o_char_counter, debug, bus.o_char_valid, ndec == 1} !== {1'b1, 10'd1, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL fetch0_send: got sends=%0d cnt=%0d dbg=%b val=%b dec=%0d, want 1 1 0 0 1",
                     sent.size(), bus.o_char_counter, debug, bus.o_char_valid, ndec);
        end
        drive_edge();
        busy = 1'b1;
    endtask
    task automatic test_busy;
        for (int i = 0; i < 100 && ndec < 2; i++) nclk(1);
        nclk(20);
        vectors++;
        if ({bus.o_char_valid, debug, phase, sent.size() == 1, bus.o_char_to_send} !== {2'b11, 2'd0, 1'b1, 8'h31}) begin
            errors++;
            $display("FAIL busy_hold: got val=%b dbg=%b ph=%0d sends=%0d chr=%h, want 1 1 0 1 31",
                     bus.o_char_valid, debug, phase, sent.size(), bus.o_char_to_send);
        end
        drive_edge();
        busy = 1'b0;
        for (int i = 0; i < 20 && debug; i++) nclk(1);
        vectors++;
        if ({sent.size() == 2, bus.o_char_counter, debug} !== {1'b1, 10'd2, 1'b0}) begin
            errors++;
            $display("FAIL busy_release: got sends=%0d cnt=%0d dbg=%b, want 2 2 0", sent.size(), bus.o_char_counter, debug);
        end else begin
            vectors++;
            if (sent[1] !== 8'h31) begin
                errors++;
                $display("FAIL busy_char: got %h, want 31", sent[1]);
            end
        end
    endtask
    task automatic test_line;
        for (int i = 0; i < 500 && (ndec < 16 || debug); i++) nclk(1);
        vectors++;
        if ({bus.o_char_counter, sent.size() == 18} !== {10'd18, 1'b1}) begin
            errors++;
            $display("FAIL line_count: got cnt=%0d sends=%0d, want 18 18", bus.o_char_counter, sent.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (sent[k] !== 8'(hx[rom(20'(k))])) begin
                    errors++;
                    $display("FAIL line_char%0d: got %h, want %h", k, sent[k], 8'(hx[rom(20'(k))]));
                end
            end
            vectors++;
            if ({sent[15], sent[16], sent[17]} !== {8'h33, 8'h0D, 8'h0A}) begin
                errors++;
                $display("FAIL line_crlf: got %h %h %h, want 33 0d 0a", sent[15], sent[16], sent[17]);
            end
        end
    endtask
    task automatic test_clk_en;
        logic [1:0] p;
        for (int i = 0; i < 100 && ndec < 17; i++) nclk(1);
        clk_en = 1'b0;
        p = phase;
        nclk(10);
        vectors++;
        if ({decoded, bus.o_char_valid, bus.o_char_send, bus.o_char_counter, phase == p, ndec} !== {3'b110, 10'd18, 1'b1, 32'd17}) begin
            errors++;
            $display("FAIL clken_freeze: got dec=%b val=%b snd=%b cnt=%0d ph=%0d ndec=%0d, want 1 1 0 18 %0d 17",
                     decoded, bus.o_char_valid, bus.o_char_send, bus.o_char_counter, phase, ndec, p);
        end
        drive_edge();
        clk_en = 1'b1;
        for (int i = 0; i < 20 && debug; i++) nclk(1);
        vectors++;
        if ({bus.o_char_counter, ndec, sent[18]} !== {10'd19, 32'd17, 8'h41}) begin
            errors++;
            $display("FAIL clken_resume: got cnt=%0d ndec=%0d chr=%h, want 19 17 41", bus.o_char_counter, ndec, sent[18]);
        end
    endtask
    task automatic test_halt;
        int nx;
        for (int i = 0; i < 2000 && ndec < 64; i++) nclk(1);
        vectors++;
        if ({halt, debug} !== 2'b01) begin
            errors++;
            $display("FAIL halt_early: got halt=%b dbg=%b at 64th fetch, want 0 1", halt, debug);
        end
        for (int i = 0; i < 100 && !halt; i++) nclk(1);
        vectors++;
        if ({halt, debug, bus.o_char_counter, ndec, sent.size() == 72} !== {2'b10, 10'd72, 32'd64, 1'b1}) begin
            errors++;
            $display("FAIL halt_state: got halt=%b dbg=%b cnt=%0d ndec=%0d sends=%0d, want 1 0 72 64 72",
                     halt, debug, bus.o_char_counter, ndec, sent.size());
        end
        nx = xfer.size();
        nclk(100);
        vectors++;
        if ({xfer.size() == nx, halt, ndec} !== {2'b11, 32'd64}) begin
            errors++;
            $display("FAIL halt_sticky: got %0d extra transfers halt=%b ndec=%0d, want 0 1 64", xfer.size() - nx, halt, ndec);
        end
    endtask
    task automatic test_reset_mid;
        int bd, bs;
        drive_edge();
        rst_n = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        bd = ndec;
        for (int i = 0; i < 100 && ndec < bd + 1; i++) nclk(1);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({debug, decoded, halt, bus.o_bus_clk_en, bus.o_bus_is_data, bus.o_bus_nibble_out, bus.o_char_to_send,
             bus.o_char_counter, bus.o_char_valid, bus.o_char_send} !== '0) begin
            errors++;
            $display("FAIL async_reset: got dbg=%b dec=%b val=%b chr=%h cnt=%0d, want all 0",
                     debug, decoded, bus.o_char_valid, bus.o_char_to_send, bus.o_char_counter);
        end
        nclk(2);
        bs = xfer.size();
        drive_edge();
        rst_n = 1'b1;
        test_addr_cycles(bs);
        bd = ndec;
        bs = sent.size();
        for (int i = 0; i < 100 && (ndec < bd + 1 || debug); i++) nclk(1);
        vectors++;
        if ({sent.size() == bs + 1, bus.o_char_counter, bus.o_char_to_send} !== {1'b1, 10'd1, 8'h41}) begin
            errors++;
            $display("FAIL restart_fetch: got sends=%0d cnt=%0d chr=%h, want 1 1 41", sent.size() - bs, bus.o_char_counter, bus.o_char_to_send);
        end
    endtask
    initial begin
        test_reset();
        test_addr_cycles(0);
        test_first_fetch();
        test_busy();
        test_line();
        test_clk_en();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
